eth_tx_app_feeder: RTL and testbench

- Packet buffer and sequencer directly upstream of eth_tx. Accepts a payload word stream from user logic and stores it until the packet is complete.
- Per committed packet: performs the early_v/ready_v head handshake with eth_tx, then streams one word per cycle.
- Generates app_pkt_len, app_len, app_last, app_last_block_next and app_last_block_next_len with the timing eth_tx requires.

---
 rtl/eth_tx_app_feeder_if.sv | 38 +++
 rtl/eth_tx_app_feeder.sv | 131 +++++++++++++
 tb/tb_eth_tx_app_feeder.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_app_feeder_if.sv
// eth_tx_app_feeder_if: user write stream and eth_tx head/payload signals of the feeder
interface eth_tx_app_feeder_if #(
    parameter int DATA_W      = 16,
    parameter int KEEP_W      = DATA_W / 8,
    parameter int LEN_W       = $clog2(KEEP_W + 1),
    parameter int PKT_LEN_W   = 16,
    parameter int BLOCK_N     = 8,
    parameter int BLOCK_LEN_W = $clog2(BLOCK_N + 1)
);
    logic                   wr_valid_i;
    logic                   wr_ready_o;
    logic [DATA_W-1:0]      wr_data_i;
    logic [LEN_W-1:0]       wr_len_i;
    logic                   wr_last_i;
    logic                   wr_cancel_i;
    logic                   wr_drop_o;
    logic                   flush_i;
    logic                   app_early_v_o;
    logic                   app_ready_v_i;
    logic [PKT_LEN_W-1:0]   app_pkt_len_o;
    logic [DATA_W-1:0]      app_data_o;
    logic [LEN_W-1:0]       app_len_o;
    logic                   app_last_o;
    logic                   app_last_block_next_o;
    logic [BLOCK_LEN_W-1:0] app_last_block_next_len_o;
    logic                   app_cancel_o;

    modport slave (
        input  wr_valid_i, wr_data_i, wr_len_i, wr_last_i, wr_cancel_i, flush_i, app_ready_v_i,
        output wr_ready_o, wr_drop_o, app_early_v_o, app_pkt_len_o, app_data_o, app_len_o,
               app_last_o, app_last_block_next_o, app_last_block_next_len_o, app_cancel_o
    );
    modport master (
        output wr_valid_i, wr_data_i, wr_len_i, wr_last_i, wr_cancel_i, flush_i, app_ready_v_i,
        input  wr_ready_o, wr_drop_o, app_early_v_o, app_pkt_len_o, app_data_o, app_len_o,
               app_last_o, app_last_block_next_o, app_last_block_next_len_o, app_cancel_o
    );
endinterface

// File: rtl/eth_tx_app_feeder.sv
// eth_tx_app_feeder: store-and-forward packet buffer sequencing committed packets into eth_tx
module eth_tx_app_feeder #(
    parameter int DATA_W      = 16,
    parameter int KEEP_W      = DATA_W / 8,
    parameter int LEN_W       = $clog2(KEEP_W + 1),
    parameter int PKT_LEN_W   = 16,
    parameter int BLOCK_N     = 8,
    parameter int BLOCK_LEN_W = $clog2(BLOCK_N + 1),
    parameter int DEPTH       = 64,
    parameter int PKT_Q_N     = 4
) (
    input logic clk,
    input logic reset,
    eth_tx_app_feeder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int QW = $clog2(PKT_Q_N);
    localparam logic [PKT_LEN_W-1:0] KW = PKT_LEN_W'(KEEP_W);
    localparam logic [PKT_LEN_W-1:0] BN = PKT_LEN_W'(BLOCK_N);

    typedef enum logic [1:0] {IDLE, HEAD, DATA, LAST} state_t;
    state_t state, state_nx;

    logic [DATA_W-1:0]    mem [DEPTH];
    logic [PKT_LEN_W-1:0] pq [PKT_Q_N];
    logic [AW:0]          wr_ptr, commit_ptr, rd_ptr, end_ptr;
    logic [QW:0]          pq_wr, pq_rd;
    logic [PKT_LEN_W-1:0] cnt, len_r, off, head_len, full_bytes;
    logic discard, data_full, pq_full, pq_empty, oversize, ready, acc, store, flush, pop, active, lbn;

    assign head_len   = pq[pq_rd[QW-1:0]];
    assign data_full  = (wr_ptr - rd_ptr) == (AW+1)'(DEPTH);
    assign pq_full    = (pq_wr - pq_rd) == (QW+1)'(PKT_Q_N);
    assign pq_empty   = pq_wr == pq_rd;
    // A full FIFO with nothing committed can never drain: the packet cannot fit
    assign oversize   = data_full & (wr_ptr != commit_ptr) & pq_empty & !discard;
    assign ready      = discard | (!data_full & !pq_full);
    assign acc        = bus.wr_valid_i & ready & !bus.wr_cancel_i;
    assign store      = acc & !discard;
    assign bus.wr_ready_o = ready;
    assign bus.wr_drop_o  = oversize & !bus.wr_cancel_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            cnt        <= '0;
            pq_wr      <= '0;
            discard    <= 1'b0;
        end else if (bus.wr_cancel_i) begin
            wr_ptr  <= commit_ptr;
            cnt     <= '0;
            discard <= 1'b0;
        end else if (oversize) begin
            wr_ptr  <= commit_ptr;
            cnt     <= '0;
            discard <= 1'b1;
        end else if (acc & discard) begin
            discard <= !bus.wr_last_i;
        end else if (store) begin
            wr_ptr <= wr_ptr + 1'b1;
            cnt    <= bus.wr_last_i ? '0 : cnt + PKT_LEN_W'(bus.wr_len_i);
            if (bus.wr_last_i) begin
                commit_ptr <= wr_ptr + 1'b1;
                pq_wr      <= pq_wr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr[AW-1:0]] <= bus.wr_data_i;
        if (store & bus.wr_last_i) pq[pq_wr[QW-1:0]] <= cnt + PKT_LEN_W'(bus.wr_len_i);
    end

    assign flush      = bus.flush_i & (state != IDLE);
    assign pop        = flush | (state == LAST);
    assign full_bytes = (len_r / KW) * KW;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = pq_empty ? IDLE : HEAD;
            HEAD:    state_nx = !bus.app_ready_v_i ? HEAD : (full_bytes == '0) ? LAST : DATA;
            DATA:    state_nx = (off + KW == full_bytes) ? LAST : DATA;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    // end_ptr marks the word after the packet so flush and LAST share one pointer jump
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_r   <= '0;
            off     <= '0;
            rd_ptr  <= '0;
            end_ptr <= '0;
            pq_rd   <= '0;
        end else begin
            if (state == IDLE && !pq_empty) begin
                len_r   <= head_len;
                off     <= '0;
                end_ptr <= rd_ptr + (AW+1)'((head_len + KW - PKT_LEN_W'(1)) / KW);
            end
            if (pop) begin
                rd_ptr <= end_ptr;
                pq_rd  <= pq_rd + 1'b1;
            end else if (state == DATA) begin
                rd_ptr <= rd_ptr + 1'b1;
                off    <= off + KW;
            end
        end
    end

    always_comb begin
        active = (state == DATA) || (state == LAST);
        lbn    = active && (off % BN == '0) && (off / BN == len_r / BN);
        bus.app_early_v_o             = state == HEAD;
        bus.app_pkt_len_o             = (state != IDLE) ? len_r : '0;
        bus.app_data_o                = active ? mem[rd_ptr[AW-1:0]] : '0;
        bus.app_len_o                 = (state == DATA) ? LEN_W'(KEEP_W) : (state == LAST) ? LEN_W'(len_r % KW) : '0;
        bus.app_last_o                = state == LAST;
        bus.app_last_block_next_o     = lbn;
        bus.app_last_block_next_len_o = lbn ? BLOCK_LEN_W'(len_r % BN) : '0;
        bus.app_cancel_o              = flush;
    end
endmodule

// File: tb/tb_eth_tx_app_feeder.sv
// tb_eth_tx_app_feeder: scoreboard bench for the eth_tx packet feeder
module tb_eth_tx_app_feeder;
    localparam int KW = 2;

    logic clk = 1'b0;
    logic reset;
    eth_tx_app_feeder_if bus ();

    eth_tx_app_feeder dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [7:0] exp_bytes [$];
    int exp_lens [$];
    bit in_pkt = 0, have_prev = 0;
    int cur_len = 0, beat = 0, pkt_seen = 0, cancel_cnt = 0, drop_cnt = 0;
    int lbn_cnt = 0, lbn_beat = -1, head_cyc = 0, gap = 0, max_gap = 0, rdy_dly = 0;

    // eth_tx stand-in: raises ready_v rdy_dly cycles into each head
    initial begin
        int hc;
        hc = 0;
        bus.app_ready_v_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (reset || !bus.app_early_v_o) begin
                hc = 0;
                bus.app_ready_v_i = 1'b0;
            end else begin
                hc++;
                bus.app_ready_v_i = (hc == rdy_dly + 1);
            end
        end
    end

    always @(negedge clk) begin
        int x, e_len, e_lbn_len;
        bit e_last, e_lbn;
        logic [15:0] e_data, mask;
        if (reset) in_pkt = 0;
        else begin
            if (bus.app_early_v_o) head_cyc++;
            if (bus.wr_drop_o) drop_cnt++;
            if (bus.app_cancel_o) begin
                cancel_cnt++;
                if (in_pkt)
                    for (int i = beat * KW; i < cur_len; i++)
                        if (exp_bytes.size() > 0) void'(exp_bytes.pop_front());
                in_pkt = 0;
            end else begin
                if (bus.app_early_v_o && !in_pkt) begin
                    checks++;
                    if (exp_lens.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_pkt: head with pkt_len=%0d, none expected", bus.app_pkt_len_o);
                    end else begin
                        cur_len = exp_lens.pop_front();
                        in_pkt = 1;
                        beat = 0;
                        if (have_prev && gap > max_gap) max_gap = gap;
                        if (int'(bus.app_pkt_len_o) != cur_len) begin
                            errors++;
                            $display("FAIL head_pkt_len: got %0d want %0d", bus.app_pkt_len_o, cur_len);
                        end
                    end
                end
                if (in_pkt && (bus.app_len_o != 0 || bus.app_last_o)) begin
                    x = beat * KW;
                    e_last = (cur_len - x) < KW;
                    e_len = e_last ? cur_len - x : KW;
                    e_lbn = (x % 8 == 0) && (x / 8 == cur_len / 8);
                    e_lbn_len = e_lbn ? cur_len % 8 : 0;
                    e_data = '0;
                    mask = '0;
                    for (int i = 0; i < e_len; i++) begin
                        if (exp_bytes.size() > 0) e_data[8*i +: 8] = exp_bytes.pop_front();
                        mask[8*i +: 8] = 8'hff;
                    end
                    checks += 5;
                    if (int'(bus.app_len_o) != e_len) begin
                        errors++;
                        $display("FAIL beat_len: beat %0d got %0d want %0d", beat, bus.app_len_o, e_len);
                    end
                    if (bus.app_last_o !== e_last) begin
                        errors++;
                        $display("FAIL beat_last: beat %0d got %0b want %0b", beat, bus.app_last_o, e_last);
                    end
                    if ((bus.app_data_o & mask) !== e_data) begin
                        errors++;
                        $display("FAIL beat_data: beat %0d got %h want %h", beat, bus.app_data_o & mask, e_data);
                    end
                    if (int'(bus.app_pkt_len_o) != cur_len) begin
                        errors++;
                        $display("FAIL pkt_len_stable: beat %0d got %0d want %0d", beat, bus.app_pkt_len_o, cur_len);
                    end
                    if (bus.app_last_block_next_o !== e_lbn || int'(bus.app_last_block_next_len_o) != e_lbn_len) begin
                        errors++;
                        $display("FAIL last_block_next: beat %0d got %0b/%0d want %0b/%0d", beat,
                                 bus.app_last_block_next_o, bus.app_last_block_next_len_o, e_lbn, e_lbn_len);
                    end
                    if (bus.app_last_block_next_o) begin
                        lbn_cnt++;
                        lbn_beat = beat;
                    end
                    beat++;
                    if (bus.app_last_o) begin
                        in_pkt = 0;
                        pkt_seen++;
                        gap = 0;
                        have_prev = 1;
                    end
                end else if (!in_pkt) gap++;
            end
        end
    end

    task automatic write_pkt(input int len, input bit expect_out, input int cancel_after);
        logic [7:0] b [$];
        int nw, n;
        nw = (len + KW - 1) / KW;
        for (int i = 0; i < len; i++) b.push_back(8'($urandom_range(0, 255)));
        if (expect_out) begin
            exp_lens.push_back(len);
            foreach (b[i]) exp_bytes.push_back(b[i]);
        end
        for (int w = 0; w < nw; w++) begin
            if (w == cancel_after) break;
            @(posedge clk); #1;
            bus.wr_valid_i = 1'b1;
            bus.wr_last_i  = (w == nw - 1);
            bus.wr_len_i   = 2'((w == nw - 1) ? len - w * KW : KW);
            bus.wr_data_i  = {(2 * w + 1 < len) ? b[2*w+1] : 8'h00, b[2*w]};
            n = 0;
            @(negedge clk);
            while (!bus.wr_ready_o && n < 500) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n >= 500) begin
                errors++;
                $display("FAIL write_ready: word %0d not accepted, ready=%0b want 1", w, bus.wr_ready_o);
            end
        end
        @(posedge clk); #1;
        bus.wr_valid_i = 1'b0;
        bus.wr_last_i  = 1'b0;
        if (cancel_after >= 0) begin
            bus.wr_cancel_i = 1'b1;
            @(posedge clk); #1;
            bus.wr_cancel_i = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_lens.size() != 0 || in_pkt) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL drain_timeout: %0d packets pending, want 0", exp_lens.size());
        end
    endtask

    task automatic wait_data_beats(input int k);
        int nb, n;
        nb = 0;
        n = 0;
        while (nb < k && n < 500) begin
            @(negedge clk);
            if (bus.app_len_o == 2'(KW) && !bus.app_last_o) nb++;
            n++;
        end
        checks++;
        if (nb < k) begin
            errors++;
            $display("FAIL data_beat_timeout: saw %0d beats want %0d", nb, k);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({bus.app_early_v_o, bus.app_pkt_len_o, bus.app_data_o, bus.app_len_o, bus.app_last_o,
             bus.app_last_block_next_o, bus.app_last_block_next_len_o, bus.app_cancel_o, bus.wr_drop_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: early=%0b pkt_len=%0d len=%0d last=%0b want all 0",
                     bus.app_early_v_o, bus.app_pkt_len_o, bus.app_len_o, bus.app_last_o);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.wr_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: got %0b want 1", bus.wr_ready_o);
        end
    endtask

    task automatic test_len19();
        int p0;
        p0 = pkt_seen;
        rdy_dly = 2;
        head_cyc = 0;
        lbn_cnt = 0;
        lbn_beat = -1;
        write_pkt(19, 1, -1);
        wait_done();
        checks += 3;
        if (pkt_seen != p0 + 1) begin
            errors++;
            $display("FAIL len19_count: got %0d want %0d", pkt_seen - p0, 1);
        end
        if (head_cyc != 3) begin
            errors++;
            $display("FAIL len19_head_cycles: got %0d want 3", head_cyc);
        end
        if (lbn_cnt != 1 || lbn_beat != 8) begin
            errors++;
            $display("FAIL len19_lbn: count %0d at beat %0d, want 1 at beat 8", lbn_cnt, lbn_beat);
        end
    endtask

    task automatic test_len16();
        rdy_dly = 1;
        lbn_cnt = 0;
        lbn_beat = -1;
        write_pkt(16, 1, -1);
        wait_done();
        checks++;
        if (lbn_cnt != 1 || lbn_beat != 8) begin
            errors++;
            $display("FAIL len16_lbn: count %0d at beat %0d, want 1 at beat 8", lbn_cnt, lbn_beat);
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = pkt_seen;
        rdy_dly = 0;
        have_prev = 0;
        max_gap = 0;
        for (int k = 0; k < 3; k++) write_pkt(19, 1, -1);
        wait_done();
        checks += 2;
        if (pkt_seen != p0 + 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 3", pkt_seen - p0);
        end
        if (max_gap > 1) begin
            errors++;
            $display("FAIL b2b_gap: got %0d idle cycles want <= 1", max_gap);
        end
    endtask

    task automatic test_cancel();
        int p0;
        p0 = pkt_seen;
        write_pkt(12, 0, 3);
        write_pkt(5, 1, -1);
        wait_done();
        checks++;
        if (pkt_seen != p0 + 1) begin
            errors++;
            $display("FAIL cancel_count: got %0d want 1", pkt_seen - p0);
        end
    endtask

    task automatic test_oversize();
        int p0;
        p0 = pkt_seen;
        drop_cnt = 0;
        write_pkt(130, 0, -1);
        repeat (20) @(negedge clk);
        checks += 2;
        if (drop_cnt != 1) begin
            errors++;
            $display("FAIL oversize_drop: got %0d pulses want 1", drop_cnt);
        end
        if (pkt_seen != p0) begin
            errors++;
            $display("FAIL oversize_emitted: got %0d packets want 0", pkt_seen - p0);
        end
        write_pkt(4, 1, -1);
        wait_done();
        checks++;
        if (pkt_seen != p0 + 1) begin
            errors++;
            $display("FAIL oversize_next: got %0d packets want 1", pkt_seen - p0);
        end
    endtask

    task automatic test_flush();
        int p0;
        p0 = pkt_seen;
        rdy_dly = 0;
        cancel_cnt = 0;
        fork
            begin
                write_pkt(19, 1, -1);
                write_pkt(19, 1, -1);
            end
            begin
                wait_data_beats(2);
                @(posedge clk); #1;
                bus.flush_i = 1'b1;
                @(negedge clk);
                checks++;
                if (bus.app_cancel_o !== 1'b1) begin
                    errors++;
                    $display("FAIL flush_cancel: got %0b want 1", bus.app_cancel_o);
                end
                @(posedge clk); #1;
                bus.flush_i = 1'b0;
            end
        join
        wait_done();
        checks += 2;
        if (cancel_cnt != 1) begin
            errors++;
            $display("FAIL flush_pulses: got %0d want 1", cancel_cnt);
        end
        if (pkt_seen != p0 + 1) begin
            errors++;
            $display("FAIL flush_next: got %0d complete packets want 1", pkt_seen - p0);
        end
    endtask

    task automatic test_reset_mid();
        int p0;
        rdy_dly = 0;
        write_pkt(19, 1, -1);
        wait_data_beats(2);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.app_early_v_o, bus.app_pkt_len_o, bus.app_data_o, bus.app_len_o, bus.app_last_o,
             bus.app_last_block_next_o, bus.app_last_block_next_len_o, bus.app_cancel_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid: pkt_len=%0d len=%0d last=%0b want all 0",
                     bus.app_pkt_len_o, bus.app_len_o, bus.app_last_o);
        end
        exp_bytes.delete();
        exp_lens.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        p0 = pkt_seen;
        repeat (20) @(negedge clk);
        write_pkt(6, 1, -1);
        wait_done();
        checks++;
        if (pkt_seen != p0 + 1) begin
            errors++;
            $display("FAIL reset_recover: got %0d packets want 1", pkt_seen - p0);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.wr_valid_i  = 1'b0;
        bus.wr_data_i   = '0;
        bus.wr_len_i    = '0;
        bus.wr_last_i   = 1'b0;
        bus.wr_cancel_i = 1'b0;
        bus.flush_i     = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_len19();
        test_len16();
        test_back_to_back();
        test_cancel();
        test_oversize();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end
endmodule
